ssd1306_frame_sender: RTL



---
 rtl/ssd1306_frame_sender.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ssd1306_frame_sender.sv
`default_nettype none
// ============================================================================
// Module  : ssd1306_frame_sender
// Brief   : SPI master sending the SSD1306 window preamble, then a bitmap read
//           from a synchronous-read RAM, with D/C framing per byte.
// Rev     : 1.0 - initial release
// ============================================================================
module ssd1306_frame_sender #(
  parameter int CLOCK_DIVIDER = 2,
  parameter int FRAME_BYTES   = 1024,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  output logic [ADDRESS_WIDTH-1:0] ReadAddress_o,
  input  logic [7:0]               ReadData_i,
  output logic                     CS_o,
  output logic                     SCK_o,
  output logic                     MOSI_o,
  output logic                     DC_o,
  output logic                     Busy_o,
  output logic                     Done_o
);

  localparam int                 c_CMD_BYTES  = 6;
  localparam int                 c_CNT_W      = $clog2(c_CMD_BYTES + (2**ADDRESS_WIDTH) + 1);
  localparam logic [c_CNT_W-1:0] c_FIRST_DATA = c_CNT_W'(c_CMD_BYTES);
  localparam logic [c_CNT_W-1:0] c_LAST_BYTE  = c_CNT_W'(c_CMD_BYTES + FRAME_BYTES - 1);
  localparam logic [7:0]         c_TICK_MAX   = 8'(CLOCK_DIVIDER - 1);
  localparam logic [7:0]         c_PRE0       = 8'h21;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_TAIL  = 2'd3
  } state_t;

  state_t             r_state;
  logic [7:0]         r_tick;
  logic               r_half;
  logic [2:0]         r_bit;
  logic [6:0]         r_shift;   // bits still to send after the one on MOSI
  logic [c_CNT_W-1:0] r_byte;

  logic               w_tick;
  logic [c_CNT_W-1:0] w_next_byte;
  logic               w_next_is_data;
  logic               w_last;
  logic [7:0]         w_cmd_byte;

  assign w_tick         = (r_tick == c_TICK_MAX);
  assign w_next_byte    = r_byte + c_CNT_W'(1);
  assign w_next_is_data = (w_next_byte >= c_FIRST_DATA);
  assign w_last         = (r_byte == c_LAST_BYTE);

  // Preamble: column window 0..127, page window 0..7
  always_comb begin
    w_cmd_byte = c_PRE0;
    case (w_next_byte[2:0])
      3'd1:    w_cmd_byte = 8'h00;
      3'd2:    w_cmd_byte = 8'h7F;
      3'd3:    w_cmd_byte = 8'h22;
      3'd4:    w_cmd_byte = 8'h00;
      3'd5:    w_cmd_byte = 8'h07;
      default: w_cmd_byte = c_PRE0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_half        <= 1'b0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_byte        <= '0;
      ReadAddress_o <= '0;
      CS_o          <= 1'b1;
      SCK_o         <= 1'b0;
      MOSI_o        <= 1'b0;
      DC_o          <= 1'b0;
      Busy_o        <= 1'b0;
      Done_o        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Done_o <= 1'b0;
          r_tick <= '0;
          r_half <= 1'b0;
          if (Start_i) begin
            r_state <= S_SHIFT;
            Busy_o  <= 1'b1;
            CS_o    <= 1'b0;
            DC_o    <= 1'b0;
            MOSI_o  <= c_PRE0[7];
            r_shift <= c_PRE0[6:0];
            r_bit   <= '0;
            r_byte  <= '0;
          end
        end

        S_SHIFT: begin
          r_tick <= w_tick ? '0 : r_tick + 8'd1;
          if (w_tick) begin
            if (!SCK_o) begin
              SCK_o <= 1'b1;
            end else begin
              SCK_o <= 1'b0;
              if (r_bit == 3'd7) begin
                r_state <= S_GAP;
                r_half  <= 1'b0;
                // Address goes out now so the RAM word is ready when the gap ends
                if (w_next_is_data && !w_last)
                  ReadAddress_o <= (w_next_byte == c_FIRST_DATA) ? '0
                                   : ReadAddress_o + ADDRESS_WIDTH'(1);
              end else begin
                r_bit   <= r_bit + 3'd1;
                MOSI_o  <= r_shift[6];
                r_shift <= {r_shift[5:0], 1'b0};
              end
            end
          end
        end

        S_GAP: begin
          r_tick <= w_tick ? '0 : r_tick + 8'd1;
          if (w_tick) begin
            if (!r_half) begin
              r_half <= 1'b1;
            end else if (w_last) begin
              r_state <= S_TAIL;
              r_half  <= 1'b0;
              CS_o    <= 1'b1;
              MOSI_o  <= 1'b0;
            end else begin
              r_state <= S_SHIFT;
              r_half  <= 1'b0;
              r_bit   <= '0;
              r_byte  <= w_next_byte;
              DC_o    <= w_next_is_data;
              if (w_next_is_data) begin
                MOSI_o  <= ReadData_i[7];
                r_shift <= ReadData_i[6:0];
              end else begin
                MOSI_o  <= w_cmd_byte[7];
                r_shift <= w_cmd_byte[6:0];
              end
            end
          end
        end

        S_TAIL: begin
          r_tick <= w_tick ? '0 : r_tick + 8'd1;
          if (w_tick) begin
            if (!r_half) begin
              r_half <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_half  <= 1'b0;
              Busy_o  <= 1'b0;
              Done_o  <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
